// File: rtl/vending_machine_multi.sv
// Multi-item vending machine: three coin denominations, greedy change from
// saturating per-denomination inventories, refund on change failure, p/q/r property flags.
module vending_machine_multi #(
  parameter int unsigned NUM_ITEMS = 3,
  parameter int unsigned ITEM_W    = 2,
  parameter int unsigned VAL_W     = 6,
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned IN_W      = 2,
  parameter int unsigned V0        = 10,
  parameter int unsigned V1        = 5,
  parameter logic [8*NUM_ITEMS-1:0] COSTS = {8'd23, 8'd15, 8'd7},
  parameter int unsigned INIT_CNT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   coinIn0,
  input  logic [IN_W-1:0]   coinIn1,
  input  logic [IN_W-1:0]   coinIn2,
  input  logic [ITEM_W-1:0] itemTypeIn,
  output logic [CNT_W-1:0]  coinOut0,
  output logic [CNT_W-1:0]  coinOut1,
  output logic [CNT_W-1:0]  coinOut2,
  output logic [ITEM_W-1:0] itemTypeOut,
  output logic [1:0]        serviceTypeOut,
  output logic              refundOut,
  output logic              errorOut,
  output logic              p,
  output logic              q,
  output logic              r
);

  localparam int unsigned SUM_W = VAL_W + 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CNT);

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_ON   = 2'b01,
    ST_BUSY = 2'b10
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt0, r_cnt1, r_cnt2;
  logic [CNT_W-1:0]    r_out0, r_out1, r_out2;
  logic [ITEM_W-1:0]   r_item_out;
  logic [VAL_W-1:0]    r_in_val;
  logic [VAL_W-1:0]    r_svc_val;
  logic [1:0]          r_coin_type;
  logic                r_xchg_rdy;
  logic                r_refund;
  logic                r_error;
  logic                r_init;

  logic                w_req_ok;
  logic [VAL_W-1:0]    w_in_val;
  logic [VAL_W-1:0]    w_cost_req;
  logic [VAL_W-1:0]    w_cost_out;
  logic [VAL_W-1:0]    w_vk;
  logic [CNT_W-1:0]    w_cntk;
  logic                w_can_pay;
  logic [SUM_W-1:0]    w_out_sum;

  // Item cost lookup; codes outside 1..NUM_ITEMS cost nothing.
  function automatic logic [VAL_W-1:0] f_cost(input logic [ITEM_W-1:0] item);
    logic [VAL_W-1:0] c;
    c = '0;
    for (int unsigned k = 1; k <= NUM_ITEMS; k++) begin
      if (32'(item) == k) c = VAL_W'(COSTS[8*k-8 +: 8]);
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign w_req_ok   = (itemTypeIn != '0) && (32'(itemTypeIn) <= NUM_ITEMS);
  assign w_in_val   = VAL_W'(SUM_W'(V0) * SUM_W'(coinIn0) + SUM_W'(V1) * SUM_W'(coinIn1)
                           + SUM_W'(coinIn2));
  assign w_cost_req = f_cost(itemTypeIn);
  assign w_cost_out = f_cost(r_item_out);
  assign w_out_sum  = SUM_W'(V0) * SUM_W'(r_out0) + SUM_W'(V1) * SUM_W'(r_out1)
                    + SUM_W'(r_out2);

  // Value and stock of the denomination currently being paid out.
  always_comb begin
    w_vk   = '0;
    w_cntk = '0;
    case (r_coin_type)
      2'd0:    begin w_vk = VAL_W'(V0); w_cntk = r_cnt0; end
      2'd1:    begin w_vk = VAL_W'(V1); w_cntk = r_cnt1; end
      default: begin w_vk = VAL_W'(1);  w_cntk = r_cnt2; end
    endcase
  end

  assign w_can_pay = (r_svc_val >= w_vk) && (w_cntk != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_ON;
      r_cnt0      <= CNT_INIT;
      r_cnt1      <= CNT_INIT;
      r_cnt2      <= CNT_INIT;
      r_out0      <= '0;
      r_out1      <= '0;
      r_out2      <= '0;
      r_item_out  <= '0;
      r_in_val    <= '0;
      r_svc_val   <= '0;
      r_coin_type <= '0;
      r_xchg_rdy  <= 1'b0;
      r_refund    <= 1'b0;
      r_error     <= 1'b0;
      r_init      <= 1'b1;
    end else begin
      case (r_state)
        ST_ON: begin
          if (w_req_ok) begin
            r_state     <= ST_BUSY;
            r_item_out  <= itemTypeIn;
            r_in_val    <= w_in_val;
            r_cnt0      <= f_sat_add(r_cnt0, CNT_W'(coinIn0));
            r_cnt1      <= f_sat_add(r_cnt1, CNT_W'(coinIn1));
            r_cnt2      <= f_sat_add(r_cnt2, CNT_W'(coinIn2));
            r_svc_val   <= w_cost_req;
            r_out0      <= '0;
            r_out1      <= '0;
            r_out2      <= '0;
            r_coin_type <= '0;
            r_xchg_rdy  <= 1'b0;
            r_refund    <= 1'b0;
          end
        end

        ST_BUSY: begin
          if (!r_xchg_rdy) begin
            // Underpayment turns the whole payment into change.
            if (r_in_val < r_svc_val) begin
              r_svc_val  <= r_in_val;
              r_item_out <= '0;
            end else begin
              r_svc_val  <= VAL_W'(SUM_W'(r_in_val) - SUM_W'(r_svc_val));
            end
            r_xchg_rdy <= 1'b1;
          end else if (w_can_pay) begin
            case (r_coin_type)
              2'd0:    begin r_out0 <= r_out0 + 1'b1; r_cnt0 <= r_cnt0 - 1'b1; end
              2'd1:    begin r_out1 <= r_out1 + 1'b1; r_cnt1 <= r_cnt1 - 1'b1; end
              default: begin r_out2 <= r_out2 + 1'b1; r_cnt2 <= r_cnt2 - 1'b1; end
            endcase
            r_svc_val <= r_svc_val - w_vk;
          end else if (r_coin_type < 2'd2) begin
            r_coin_type <= r_coin_type + 2'd1;
          end else if (r_svc_val == '0) begin
            r_state <= ST_OFF;
          end else if (!r_refund) begin
            // Change failed: put paid coins back and refund the full input.
            r_cnt0      <= f_sat_add(r_cnt0, r_out0);
            r_cnt1      <= f_sat_add(r_cnt1, r_out1);
            r_cnt2      <= f_sat_add(r_cnt2, r_out2);
            r_out0      <= '0;
            r_out1      <= '0;
            r_out2      <= '0;
            r_svc_val   <= r_in_val;
            r_item_out  <= '0;
            r_coin_type <= '0;
            r_refund    <= 1'b1;
          end else begin
            r_error <= 1'b1;
            r_state <= ST_OFF;
          end
        end

        ST_OFF: begin
          r_out0     <= '0;
          r_out1     <= '0;
          r_out2     <= '0;
          r_item_out <= '0;
          r_svc_val  <= '0;
          r_state    <= ST_ON;
        end

        default: r_state <= ST_ON;
      endcase
    end
  end

  assign coinOut0       = r_out0;
  assign coinOut1       = r_out1;
  assign coinOut2       = r_out2;
  assign itemTypeOut    = r_item_out;
  assign serviceTypeOut = r_state;
  assign refundOut      = r_refund;
  assign errorOut       = r_error;

  // Conservation-of-value properties; all must stay low.
  assign p = r_init && (r_state == ST_OFF) && !r_error
          && (VAL_W'(w_out_sum + SUM_W'(w_cost_out)) != r_in_val);
  assign q = r_init && (r_state == ST_BUSY) && r_xchg_rdy && !r_refund && (r_item_out != '0)
          && (VAL_W'(w_out_sum + SUM_W'(r_svc_val))
              != VAL_W'(SUM_W'(r_in_val) - SUM_W'(w_cost_out)));
  assign r = r_init && (r_state == ST_ON)
          && ((r_out0 != '0) || (r_out1 != '0) || (r_out2 != '0) || (r_svc_val != '0));

endmodule
